// File: rtl/serial_pair_loader_if.sv
// Operand-pair bus between the serial pin side and the comparator side of
// serial_pair_loader. The master modport is the feeder/consumer environment.
// The slave modport is the loader itself.
interface serial_pair_loader_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sin_a;
  logic             sin_b;
  logic             out_ready;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output start,
    output sin_a,
    output sin_b,
    output out_ready,
    input  a_out,
    input  b_out,
    input  out_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  start,
    input  sin_a,
    input  sin_b,
    input  out_ready,
    output a_out,
    output b_out,
    output out_valid,
    output busy,
    output overrun
  );
endinterface

// File: rtl/serial_pair_loader.sv
// serial_pair_loader: deserialises two serial streams into the operand pair
// for the equality comparator and holds the pair stable until it is consumed.
// A frame is a one-cycle start strobe followed by WIDTH data cycles. One more
// cycle then publishes the pair. The published pair persists after the
// handshake, so the comparator result stays stable between frames.
module serial_pair_loader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_pair_loader_if.slave bus
);

  // The counter has one extra bit so that it can hold WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  // Registered state.
  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sh_a_r;
  logic [WIDTH-1:0] sh_b_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             valid_r;
  logic             busy_r;
  logic             overrun_r;

  // Next-state values.
  logic [1:0]       state_s;
  logic [CW-1:0]    cnt_s;
  logic [WIDTH-1:0] sh_a_s;
  logic [WIDTH-1:0] sh_b_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             valid_s;
  logic             busy_s;
  logic             overrun_s;

  // Shift one serial bit into an operand in the configured bit order.
  // MSB-first shifts left, so the first bit ends up in the top position.
  // LSB-first shifts right, so the first bit ends up in bit 0.
  function automatic logic [WIDTH-1:0] shift_in(
    input logic [WIDTH-1:0] cur,
    input logic             bit_in
  );
    logic [WIDTH-1:0] res;
    if (MSB_FIRST) begin
      res = {cur[WIDTH-2:0], bit_in};
    end else begin
      res = {bit_in, cur[WIDTH-1:1]};
    end
    return res;
  endfunction

  // Frame sequencing: next state, sampling, publication and overrun detection.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    sh_a_s    = sh_a_r;
    sh_b_s    = sh_b_r;
    a_s       = a_r;
    b_s       = b_r;
    valid_s   = valid_r;
    overrun_s = overrun_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_SHIFT;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        // start is deliberately not looked at here.
        if (cnt_r == CNT_FULL) begin
          // All WIDTH bits are in, so publish the pair.
          a_s     = sh_a_r;
          b_s     = sh_b_r;
          valid_s = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = ST_HOLD;
        end else begin
          sh_a_s  = shift_in(sh_a_r, bus.sin_a);
          sh_b_s  = shift_in(sh_b_r, bus.sin_b);
          cnt_s   = cnt_r + CNT_ONE;
          state_s = ST_SHIFT;
        end
      end

      ST_HOLD: begin
        if (valid_r && bus.out_ready) begin
          // Transfer completes. A start in the same cycle chains straight
          // into a new frame and is not an overrun.
          valid_s = 1'b0;
          cnt_s   = CNT_ZERO;
          if (bus.start) begin
            state_s = ST_SHIFT;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          // The pair is still unconsumed. A start now is dropped and flagged.
          state_s = ST_HOLD;
          if (bus.start) begin
            overrun_s = 1'b1;
          end else begin
            overrun_s = overrun_r;
          end
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle without a pair.
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        valid_s = 1'b0;
      end
    endcase

    busy_s = (state_s == ST_SHIFT);
  end

  // State and output registers. Async reset drops any partial frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      sh_a_r    <= {WIDTH{1'b0}};
      sh_b_r    <= {WIDTH{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      sh_a_r    <= sh_a_s;
      sh_b_r    <= sh_b_s;
      a_r       <= a_s;
      b_r       <= b_s;
      valid_r   <= valid_s;
      busy_r    <= busy_s;
      overrun_r <= overrun_s;
    end
  end

  assign bus.a_out     = a_r;
  assign bus.b_out     = b_r;
  assign bus.out_valid = valid_r;
  assign bus.busy      = busy_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_serial_pair_loader.sv
// Directed bench for serial_pair_loader. It has an MSB-first instance and an
// LSB-first instance. Both instances see the same serial stimulus, so the
// LSB-first pair is the bit-reverse of the MSB-first pair.
module tb_serial_pair_loader;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  serial_pair_loader_if #(.WIDTH(8)) if_m ();
  serial_pair_loader_if #(.WIDTH(8)) if_l ();

  serial_pair_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_m.slave)
  );

  serial_pair_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_l.slave)
  );

  assign if_l.start     = if_m.start;
  assign if_l.sin_a     = if_m.sin_a;
  assign if_l.sin_b     = if_m.sin_b;
  assign if_l.out_ready = if_m.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      failed = failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an optional start strobe, then 8 data cycles with a and b sent
  // MSB first. Check that the pair appears exactly one edge after the last bit.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input bit with_start);
    if (with_start) begin
      if_m.start = 1'b1;
      tick();
      if_m.start = 1'b0;
      check("busy_after_start", {31'd0, if_m.busy}, 32'd1);
    end
    for (int i = 7; i >= 0; i--) begin
      if_m.sin_a = a[i];
      if_m.sin_b = b[i];
      tick();
    end
    if_m.sin_a = 1'b0;
    if_m.sin_b = 1'b0;
    check("valid_low_after_8_bits", {31'd0, if_m.out_valid}, 32'd0);
    tick();
    check("valid_after_9", {31'd0, if_m.out_valid}, 32'd1);
    check("busy_in_hold", {31'd0, if_m.busy}, 32'd0);
  endtask

  initial begin
    tests          = 0;
    failed         = 0;
    rst_n          = 1'b0;
    if_m.start     = 1'b0;
    if_m.sin_a     = 1'b0;
    if_m.sin_b     = 1'b0;
    if_m.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_a", {24'd0, if_m.a_out}, 32'h00);
    check("rst_b", {24'd0, if_m.b_out}, 32'h00);
    check("rst_valid", {31'd0, if_m.out_valid}, 32'd0);
    check("rst_busy", {31'd0, if_m.busy}, 32'd0);
    check("rst_overrun", {31'd0, if_m.overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: 3C / 5A, unequal
    send_frame(8'h3C, 8'h5A, 1'b1);
    check("t1_a", {24'd0, if_m.a_out}, 32'h3C);
    check("t1_b", {24'd0, if_m.b_out}, 32'h5A);
    check("t1_equal", {31'd0, (if_m.a_out == if_m.b_out)}, 32'd0);
    if_m.out_ready = 1'b1;
    tick();
    if_m.out_ready = 1'b0;
    check("t1_valid_cleared", {31'd0, if_m.out_valid}, 32'd0);
    check("t1_idle_busy", {31'd0, if_m.busy}, 32'd0);

    // 2: BC / BC with out_ready held high
    if_m.out_ready = 1'b1;
    send_frame(8'hBC, 8'hBC, 1'b1);
    check("t2_equal", {31'd0, (if_m.a_out == if_m.b_out)}, 32'd1);
    check("t2_lsb_a", {24'd0, if_l.a_out}, 32'h3D);
    tick();
    check("t2_valid_one_cycle", {31'd0, if_m.out_valid}, 32'd0);
    check("t2_a_retained", {24'd0, if_m.a_out}, 32'hBC);
    check("t2_b_retained", {24'd0, if_m.b_out}, 32'hBC);
    if_m.out_ready = 1'b0;

    // 3: consumer stalls for 5 cycles
    send_frame(8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", {31'd0, if_m.out_valid}, 32'd1);
      check("t3_hold_a", {24'd0, if_m.a_out}, 32'h12);
      check("t3_hold_b", {24'd0, if_m.b_out}, 32'h34);
    end
    check("t3_lsb_a", {24'd0, if_l.a_out}, 32'h48);
    check("t3_lsb_b", {24'd0, if_l.b_out}, 32'h2C);
    if_m.out_ready = 1'b1;
    tick();
    if_m.out_ready = 1'b0;
    check("t3_valid_cleared", {31'd0, if_m.out_valid}, 32'd0);
    tick();
    check("t3_idle_busy", {31'd0, if_m.busy}, 32'd0);
    check("t3_idle_valid", {31'd0, if_m.out_valid}, 32'd0);

    // 4: start in HOLD without ready -> overrun; then start with ready chains
    send_frame(8'h66, 8'h99, 1'b1);
    if_m.start = 1'b1;
    tick();
    if_m.start = 1'b0;
    check("t4_overrun_set", {31'd0, if_m.overrun}, 32'd1);
    check("t4_valid_kept", {31'd0, if_m.out_valid}, 32'd1);
    check("t4_a_kept", {24'd0, if_m.a_out}, 32'h66);
    check("t4_busy_low", {31'd0, if_m.busy}, 32'd0);
    if_m.start     = 1'b1;
    if_m.out_ready = 1'b1;
    tick();
    if_m.start     = 1'b0;
    if_m.out_ready = 1'b0;
    check("t4_chain_valid", {31'd0, if_m.out_valid}, 32'd0);
    check("t4_chain_busy", {31'd0, if_m.busy}, 32'd1);
    send_frame(8'h0F, 8'hF0, 1'b0);
    check("t4_new_a", {24'd0, if_m.a_out}, 32'h0F);
    check("t4_new_b", {24'd0, if_m.b_out}, 32'hF0);
    check("t4_overrun_sticky", {31'd0, if_m.overrun}, 32'd1);
    if_m.out_ready = 1'b1;
    tick();
    if_m.out_ready = 1'b0;

    // 5: async reset after 4 bits, then a clean frame
    if_m.start = 1'b1;
    tick();
    if_m.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_m.sin_a = 1'b1;
      if_m.sin_b = 1'b1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_a", {24'd0, if_m.a_out}, 32'h00);
    check("t5_rst_b", {24'd0, if_m.b_out}, 32'h00);
    check("t5_rst_busy", {31'd0, if_m.busy}, 32'd0);
    check("t5_rst_overrun", {31'd0, if_m.overrun}, 32'd0);
    check("t5_rst_valid", {31'd0, if_m.out_valid}, 32'd0);
    #2;
    rst_n      = 1'b1;
    if_m.sin_a = 1'b0;
    if_m.sin_b = 1'b0;
    tick();
    check("t5_idle_after_rst", {31'd0, if_m.busy}, 32'd0);
    send_frame(8'hFF, 8'h00, 1'b1);
    check("t5_a", {24'd0, if_m.a_out}, 32'hFF);
    check("t5_b", {24'd0, if_m.b_out}, 32'h00);
    check("t5_lsb_a", {24'd0, if_l.a_out}, 32'hFF);
    if_m.out_ready = 1'b1;
    tick();
    if_m.out_ready = 1'b0;

    // 6: serial stream 1,0,0,0,0,0,0,0 -> 80 MSB-first, 01 LSB-first
    send_frame(8'h80, 8'h01, 1'b1);
    check("t6_msb_a", {24'd0, if_m.a_out}, 32'h80);
    check("t6_lsb_a", {24'd0, if_l.a_out}, 32'h01);
    check("t6_lsb_b", {24'd0, if_l.b_out}, 32'h80);
    if_m.out_ready = 1'b1;
    tick();
    if_m.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
